// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared FSM state type and default parameters for avg_arbiter
package avg_pkg;

    localparam int DEF_NOF_BITS  = 32;
    localparam int DEF_NOF_CH    = 4;
    localparam int DEF_TO_CYCLES = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_WAIT_FIRST = 3'd2,
        S_STREAM     = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_RESULT     = 3'd5
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
//
// Ports:
//   req   in  N  request vector
//   ptr   in  W  starting search position
//   valid out 1  at least one request set
//   idx   out W  index of the chosen request
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Two passes emulate the wrap-around: indices at or above ptr first,
    // then the ones below it.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/avg_arbiter.sv
// rtl/avg_arbiter.sv - round-robin arbiter sharing one frame averager among NOF_CH channels
//
// Optional build macro: AVG_ARB_STATS_EN adds per-channel success counters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ch_req/first/last [CH]   per-channel request and frame strobes
//   ch_data [CH*BITS]        per-channel samples, channel i at [i*NOF_BITS +: NOF_BITS]
//   ch_gnt [CH]              one-hot grant, zero when idle
//   avg_start/first/last     start pulse and forwarded strobes to the averager
//   avg_data [BITS]          forwarded sample
//   avg_done, avg_result     averager result handshake
//   res_valid/ch/data/to     one-cycle result pulse, owner, value, timeout flag
//   stat_sel, stat_cnt       (AVG_ARB_STATS_EN only) counter select / value
module avg_arbiter
    import avg_pkg::*;
#(
    parameter int NOF_BITS  = DEF_NOF_BITS,
    parameter int NOF_CH    = DEF_NOF_CH,
    parameter int TO_CYCLES = DEF_TO_CYCLES,
    localparam int CH_W     = $clog2(NOF_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NOF_CH-1:0]          ch_req,
    input  logic [NOF_CH-1:0]          ch_first,
    input  logic [NOF_CH-1:0]          ch_last,
    input  logic [NOF_CH*NOF_BITS-1:0] ch_data,
    output logic [NOF_CH-1:0]          ch_gnt,
    output logic                       avg_start,
    output logic                       avg_first,
    output logic                       avg_last,
    output logic [NOF_BITS-1:0]        avg_data,
    input  logic                       avg_done,
    input  logic [NOF_BITS:0]          avg_result,
    output logic                       res_valid,
    output logic [CH_W-1:0]            res_ch,
    output logic [NOF_BITS:0]          res_data,
`ifdef AVG_ARB_STATS_EN
    input  logic [CH_W-1:0]            stat_sel,
    output logic [15:0]                stat_cnt,
`endif
    output logic                       res_to
);

    localparam int TO_W = $clog2(TO_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [NOF_BITS:0]   res_data_q, res_data_d;
    logic                res_to_q, res_to_d;

    logic                pick_valid;
    logic [CH_W-1:0]     pick_idx;

    logic [NOF_BITS-1:0] sel_data;
    logic                sel_first;
    logic                sel_last;
    logic [NOF_CH-1:0]   gnt_vec;
    logic                fwd;

    rr_pick #(
        .N (NOF_CH),
        .W (CH_W)
    ) u_rr_pick (
        .req   (ch_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Mux of the granted channel's inputs; other channels never reach the FSM.
    always_comb begin
        sel_data  = '0;
        sel_first = 1'b0;
        sel_last  = 1'b0;
        gnt_vec   = '0;
        for (int i = 0; i < NOF_CH; i++) begin
            if (g_q == CH_W'(i)) begin
                sel_data   = ch_data[i*NOF_BITS +: NOF_BITS];
                sel_first  = ch_first[i];
                sel_last   = ch_last[i];
                gnt_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            rr_ptr_q   <= '0;
            to_cnt_q   <= '0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            res_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            rr_ptr_q   <= rr_ptr_d;
            to_cnt_q   <= to_cnt_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            res_to_q   <= res_to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        rr_ptr_d   = rr_ptr_q;
        to_cnt_d   = to_cnt_q;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        res_to_d   = res_to_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                if (sel_first && sel_last) begin
                    state_d = S_WAIT_DONE;
                end else if (sel_first) begin
                    state_d = S_STREAM;
                end else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                    // No first beat within the window: report an empty result.
                    res_ch_d   = g_q;
                    res_data_d = '0;
                    res_to_d   = 1'b1;
                    state_d    = S_RESULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_STREAM: begin
                if (sel_last) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (avg_done) begin
                    res_ch_d   = g_q;
                    res_data_d = avg_result;
                    res_to_d   = 1'b0;
                    state_d    = S_RESULT;
                end
            end
            S_RESULT: begin
                rr_ptr_d = (g_q == CH_W'(NOF_CH - 1)) ? '0 : g_q + CH_W'(1);
                res_to_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fwd       = (state_q == S_WAIT_FIRST) || (state_q == S_STREAM);
    assign ch_gnt    = (state_q != S_IDLE) ? gnt_vec : '0;
    assign avg_start = (state_q == S_START);
    assign avg_first = (state_q == S_WAIT_FIRST) && sel_first;
    assign avg_last  = fwd && sel_last;
    assign avg_data  = fwd ? sel_data : '0;
    assign res_valid = (state_q == S_RESULT);
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    // res_to_q is only ever set on the way into RESULT and cleared on exit.
    assign res_to    = res_to_q;

`ifdef AVG_ARB_STATS_EN
    logic [15:0] stat_q [NOF_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NOF_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else if ((state_q == S_RESULT) && !res_to_q) begin
            for (int i = 0; i < NOF_CH; i++) begin
                if ((g_q == CH_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NOF_CH; i++) begin
            if (stat_sel == CH_W'(i)) begin
                stat_cnt = stat_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_avg_arbiter.sv
// tb/tb_avg_arbiter.sv - scoreboard bench for avg_arbiter with a behavioural averager
module tb_avg_arbiter;

    localparam int NB = 32;
    localparam int NC = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NC-1:0]  ch_req = '0;
    logic [NC-1:0]  ch_first = '0;
    logic [NC-1:0]  ch_last = '0;
    logic [NB-1:0]  dat [NC];
    logic [NC*NB-1:0] ch_data;
    logic [NC-1:0]  ch_gnt;
    logic           avg_start, avg_first, avg_last;
    logic [NB-1:0]  avg_data;
    logic           avg_done = 1'b0;
    logic [NB:0]    avg_result = '0;
    logic           res_valid, res_to;
    logic [1:0]     res_ch;
    logic [NB:0]    res_data;

    assign ch_data = {dat[3], dat[2], dat[1], dat[0]};

    typedef struct {
        int          ch;
        logic [NB:0] data;
        bit          to;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_start  = 0;

    always #5 clk = ~clk;

    avg_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ch_req     (ch_req),
        .ch_first   (ch_first),
        .ch_last    (ch_last),
        .ch_data    (ch_data),
        .ch_gnt     (ch_gnt),
        .avg_start  (avg_start),
        .avg_first  (avg_first),
        .avg_last   (avg_last),
        .avg_data   (avg_data),
        .avg_done   (avg_done),
        .avg_result (avg_result),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .res_to     (res_to)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Behavioural averager: sums beats from first to last, answers two cycles later.
    initial begin
        longint sum;
        int     cnt, dly;
        bit     in_frame;
        sum = 0; cnt = 0; dly = 0; in_frame = 0;
        forever begin
            @(negedge clk);
            avg_done = 1'b0;
            if (rst) begin
                in_frame = 0;
                dly      = 0;
            end else begin
                if (avg_start) in_frame = 0;
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        avg_done   = 1'b1;
                        avg_result = 33'(sum / longint'(cnt));
                    end
                end
                if (avg_first) begin
                    sum = longint'(avg_data); cnt = 1; in_frame = 1;
                end else if (in_frame) begin
                    sum += longint'(avg_data); cnt++;
                end
                if (in_frame && avg_last) begin
                    in_frame = 0;
                    dly      = 2;
                end
            end
        end
    end

    // Result monitor: every res_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (avg_start) n_start++;
                if (res_valid) begin
                    if (sb.size() == 0) begin
                        chk("res_unexpected", {63'b0, res_valid}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_ch", res_ch, e.ch);
                        chk("res_data", res_data, e.data);
                        chk("res_to", res_to, e.to);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int onehot_idx(input logic [NC-1:0] g);
        int r;
        r = -1;
        if ($countones(g) == 1) begin
            for (int i = 0; i < NC; i++) if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic wait_gnt(output int ch);
        ch = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ch_gnt != '0) begin
                ch = onehot_idx(ch_gnt);
                break;
            end
        end
    endtask

    task automatic send_frame(input int ch, input int n, input int d0, input int d1,
                              input int d2, input bit intf);
        int d [3];
        d = '{d0, d1, d2};
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #1;
            dat[ch]  = NB'(d[b]);
            ch_first = ((b == 0) ? 4'(1 << ch) : 4'b0) | ((intf && (b % 2 == 0)) ? 4'b1000 : 4'b0);
            ch_last  = ((b == n - 1) ? 4'(1 << ch) : 4'b0) | ((intf && (b % 2 == 0)) ? 4'b1000 : 4'b0);
            if (intf) dat[3] = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("avg_data", avg_data, d[b]);
            chk("avg_first", avg_first, (b == 0));
            chk("avg_last", avg_last, (b == n - 1));
        end
        @(posedge clk); #1;
        ch_first = '0;
        ch_last  = '0;
        foreach (dat[i]) dat[i] = '0;
    endtask

    task automatic wait_results();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("results_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int g, s0, lat;
        foreach (dat[i]) dat[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", ch_gnt, 0);
        chk("rst_start", avg_start, 0);
        chk("rst_fwd", {avg_first, avg_last, avg_data}, 0);
        chk("rst_res", {res_valid, res_to, res_ch}, 0);
        chk("rst_res_data", res_data, 0);
        rst = 1'b0;

        // Single channel 1: 10,20,30 -> 20.
        s0 = n_start;
        ch_req = 4'b0010;
        wait_gnt(g);
        chk("t1_gnt_vec", ch_gnt, 4'b0010);
        ch_req = '0;
        sb.push_back('{1, 33'd20, 1'b0});
        send_frame(1, 3, 10, 20, 30, 1'b0);
        wait_results();
        chk("t1_start_pulses", n_start - s0, 1);

        // Single-beat frame on channel 0 (pointer is 2, wraps to 0).
        ch_req = 4'b0001;
        wait_gnt(g);
        chk("t2_grant", g, 0);
        ch_req = '0;
        sb.push_back('{0, 33'd7, 1'b0});
        send_frame(0, 1, 7, 0, 0, 1'b0);
        wait_results();

        // Reset in STREAM on channel 2: everything clears, no result.
        ch_req = 4'b0100;
        wait_gnt(g);
        chk("t3_grant", g, 2);
        ch_req = '0;
        @(posedge clk); #1;
        dat[2] = 5; ch_first = 4'b0100;
        @(posedge clk); #1;
        dat[2] = 6; ch_first = '0;
        #1 rst = 1'b1;
        #1;
        chk("t3_rst_gnt", ch_gnt, 0);
        chk("t3_rst_fwd", {avg_start, avg_first, avg_last, avg_data}, 0);
        chk("t3_rst_res", {res_valid, res_to, res_ch}, 0);
        chk("t3_rst_res_data", res_data, 0);
        dat[2] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fairness: all request, grants rotate 0,1,2,3,0 starting at 0 after reset.
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            chk("t4_grant_order", g, k % 4);
            if (k == 4) ch_req = '0;
            sb.push_back('{k % 4, 33'((k % 4) * 10 + 3), 1'b0});
            send_frame(k % 4, 2, (k % 4) * 10 + 2, (k % 4) * 10 + 4, 0, 1'b0);
            wait_results();
        end

        // Timeout on channel 2, then channel 3 gets the next grant.
        ch_req = 4'b1100;
        wait_gnt(g);
        chk("t5_grant", g, 2);
        sb.push_back('{2, 33'd0, 1'b1});
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        chk("t5_timeout_latency", lat, 8);
        @(negedge clk);
        chk("t5_gnt_released", ch_gnt, 0);
        wait_gnt(g);
        chk("t5_next_grant", g, 3);
        ch_req = '0;
        sb.push_back('{3, 33'd150, 1'b0});
        send_frame(3, 2, 100, 200, 0, 1'b0);
        wait_results();

        // Interference: channel 3 strobes while channel 0 streams 40,50,60.
        ch_req = 4'b0001;
        wait_gnt(g);
        chk("t6_grant", g, 0);
        ch_req = '0;
        sb.push_back('{0, 33'd50, 1'b0});
        send_frame(0, 3, 40, 50, 60, 1'b1);
        wait_results();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
